tx_result_sequencer: RTL and testbench

- Sequences transmission of the ALU result back to the host over the UART transmitter, one byte at a time.
- Sits between the receive-side command controller, which asserts `trigger` after the command byte is stored, and `uart_tx`, which owns the serial line.
- Latches the result, then drives the transmitter's start/busy handshake once per byte, least-significant byte first.
- Enforces a programmable idle gap between bytes.

---
 rtl/tx_result_sequencer.sv | 138 +++++++++++++
 tb/tb_tx_result_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_result_sequencer.sv
// tx_result_sequencer: streams a latched ALU result LSB-first through uart_tx.
// Optional TX_CHECKSUM_EN appends an XOR checksum byte after the result bytes.
module tx_result_sequencer #(
    parameter int N_BYTES    = 2,
    parameter int GAP_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trigger,
    input  logic [8*N_BYTES-1:0] result,
    input  logic                 tx_busy,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic                 done
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef TX_CHECKSUM_EN
    localparam int N_FRAMES = N_BYTES + 1;
`else
    localparam int N_FRAMES = N_BYTES;
`endif
    localparam int IW = (N_FRAMES > 1) ? $clog2(N_FRAMES) : 1;
    localparam logic [IW-1:0] LAST = IW'(N_FRAMES - 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LATCH   = 4'd1;
    localparam logic [3:0] S_ARM     = 4'd2;
    localparam logic [3:0] S_LAUNCH  = 4'd3;
    localparam logic [3:0] S_WAIT_HI = 4'd4;
    localparam logic [3:0] S_WAIT_LO = 4'd5;
    localparam logic [3:0] S_GAP     = 4'd6;
    localparam logic [3:0] S_NEXT    = 4'd7;
    localparam logic [3:0] S_FINISH  = 4'd8;

    logic [3:0]           state;
    logic [8*N_BYTES-1:0] shadow;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        idx_nxt;
    logic [GW-1:0]        gap_cnt;
    logic [7:0]           nxt_byte;

`ifdef TX_CHECKSUM_EN
    logic [7:0] csum;

    always_comb begin
        csum = 8'h00;
        for (int k = 0; k < N_BYTES; k++)
            csum = csum ^ shadow[8*k +: 8];
    end
`endif

    // Byte for the frame after the current one; index past the result is the checksum.
    always_comb begin
        idx_nxt  = idx + IW'(1);
        nxt_byte = 8'h00;
        for (int k = 0; k < N_BYTES; k++)
            if (idx_nxt == IW'(k))
                nxt_byte = shadow[8*k +: 8];
`ifdef TX_CHECKSUM_EN
        if (idx_nxt == IW'(N_BYTES))
            nxt_byte = csum;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            shadow  <= '0;
            idx     <= '0;
            gap_cnt <= '0;
            tx_data <= 8'h00;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (trigger) begin
                        shadow <= result;
                        busy   <= 1'b1;
                        state  <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    idx     <= '0;
                    tx_data <= shadow[7:0];
                    state   <= S_ARM;
                end
                S_ARM: begin
                    if (!tx_busy)
                        state <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    state <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (tx_busy)
                        state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_busy) begin
                        if (GAP_CYCLES == 0) begin
                            state <= S_NEXT;
                        end else begin
                            gap_cnt <= GW'(GAP_CYCLES);
                            state   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    gap_cnt <= gap_cnt - GW'(1);
                    if (gap_cnt == GW'(1))
                        state <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx == LAST) begin
                        state <= S_FINISH;
                    end else begin
                        idx     <= idx_nxt;
                        tx_data <= nxt_byte;
                        state   <= S_ARM;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_start = (state == S_LAUNCH);
    assign done     = (state == S_FINISH);

endmodule

// File: tb/tb_tx_result_sequencer.sv
// Bench for tx_result_sequencer: two instances (gap 4 and gap 0) with a uart_tx model.
// Frame count follows TX_CHECKSUM_EN when defined.
`timescale 1ns/1ps
module tb_tx_result_sequencer;

    localparam int NB   = 2;
    localparam int G0   = 4;
    localparam int G1   = 0;
    localparam int HMAX = 16384;
    localparam int EMAX = 256;
`ifdef TX_CHECKSUM_EN
    localparam int NF = NB + 1;
`else
    localparam int NF = NB;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        trig [2];
    logic [15:0] res [2];
    logic        txb [2] = '{1'b0, 1'b0};
    logic        tx_start [2];
    logic [7:0]  tx_data [2];
    logic        busy [2];
    logic        done [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic       bh [2][HMAX];
    logic       yh [2][HMAX];
    logic [7:0] dh [2][HMAX];
    int         st_c [2][EMAX];
    logic [7:0] st_d [2][EMAX];
    int         dn_c [2][EMAX];
    int         n_st [2] = '{0, 0};
    int         n_dn [2] = '{0, 0};
    bit         pend [2] = '{1'b0, 1'b0};
    bit         hold [2] = '{1'b0, 1'b0};
    int         cnt  [2] = '{0, 0};

    tx_result_sequencer #(.N_BYTES(NB), .GAP_CYCLES(G0)) u_dut0 (
        .clk(clk), .reset(reset), .trigger(trig[0]), .result(res[0]),
        .tx_busy(txb[0]), .tx_start(tx_start[0]), .tx_data(tx_data[0]),
        .busy(busy[0]), .done(done[0])
    );

    tx_result_sequencer #(.N_BYTES(NB), .GAP_CYCLES(G1)) u_dut1 (
        .clk(clk), .reset(reset), .trigger(trig[1]), .result(res[1]),
        .tx_busy(txb[1]), .tx_start(tx_start[1]), .tx_data(tx_data[1]),
        .busy(busy[1]), .done(done[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record per-cycle history and events mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cyc < HMAX) begin
                bh[i][cyc] = txb[i];
                yh[i][cyc] = busy[i];
                dh[i][cyc] = tx_data[i];
            end
            if (tx_start[i] === 1'b1) begin
                chk("start_while_line_busy", 64'(txb[i]), 64'd0);
                if (n_st[i] < EMAX) begin
                    st_c[i][n_st[i]] = cyc;
                    st_d[i][n_st[i]] = tx_data[i];
                end
                n_st[i]++;
                pend[i] = 1'b1;
            end
            if (done[i] === 1'b1) begin
                if (n_dn[i] < EMAX)
                    dn_c[i][n_dn[i]] = cyc;
                n_dn[i]++;
            end
        end
    end

    // uart_tx model: busy for a random 1..12 cycles starting the cycle after tx_start.
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 2; i++) begin
            if (hold[i]) begin
                txb[i]  = 1'b1;
                pend[i] = 1'b0;
            end else if (pend[i]) begin
                pend[i] = 1'b0;
                cnt[i]  = int'($urandom_range(0, 11));
                txb[i]  = 1'b1;
            end else if (cnt[i] > 0) begin
                cnt[i]--;
                txb[i] = 1'b1;
            end else begin
                txb[i] = 1'b0;
            end
        end
    end

    function automatic int find(input int i, input int from, input logic v);
        for (int c = from; c < cyc && c < HMAX; c++)
            if (bh[i][c] === v)
                return c;
        return -1000;
    endfunction

    // Expected timeline from the handshake rules applied to the recorded tx_busy line.
    task automatic check_txn(input int i, input int t, input logic [15:0] v,
                             input int s0, input int d0);
        logic [7:0] eb [NF];
        int g, c, h, f, dexp, miss;
        g = (i == 0) ? G0 : G1;
        for (int k = 0; k < NB; k++)
            eb[k] = v[8*k +: 8];
`ifdef TX_CHECKSUM_EN
        eb[NB] = 8'h00;
        for (int k = 0; k < NB; k++)
            eb[NB] = eb[NB] ^ eb[k];
`endif
        chk("frame_count", 64'(n_st[i] - s0), 64'(NF));
        chk("done_count", 64'(n_dn[i] - d0), 64'd1);
        chk("busy_before_trigger", 64'(yh[i][t]), 64'd0);
        dexp = 0;
        c = find(i, t + 2, 1'b0) + 1;
        for (int k = 0; k < NF; k++) begin
            if (s0 + k < EMAX) begin
                chk("start_cycle", 64'(st_c[i][s0+k]), 64'(c));
                chk("frame_byte", 64'(st_d[i][s0+k]), 64'(eb[k]));
            end
            h = find(i, c + 1, 1'b1);
            f = find(i, h + 1, 1'b0);
            miss = 0;
            for (int cc = c; cc <= f && cc >= 0 && cc < HMAX; cc++)
                if (dh[i][cc] !== eb[k])
                    miss++;
            chk("data_hold_cycles_bad", 64'(miss), 64'd0);
            if (k == NF - 1)
                dexp = f + g + 2;
            else
                c = find(i, f + g + 2, 1'b0) + 1;
        end
        if (d0 < EMAX)
            chk("done_cycle", 64'(dn_c[i][d0]), 64'(dexp));
        miss = 0;
        for (int cc = t + 1; cc <= dexp && cc < HMAX; cc++)
            if (yh[i][cc] !== 1'b1)
                miss++;
        chk("busy_span_cycles_bad", 64'(miss), 64'd0);
    endtask

    task automatic run(input int i, input logic [15:0] v, input bit retrig,
                       input int hold_cyc);
        int t, s0, d0, n;
        bit fired;
        s0 = n_st[i];
        d0 = n_dn[i];
        t = cyc;
        fired = 1'b0;
        trig[i] = 1'b1;
        res[i] = v;
        @(posedge clk); #1;
        trig[i] = 1'b0;
        res[i] = 16'($urandom);
        n = 0;
        while (n_dn[i] == d0 && n < 3000) begin
            if (hold_cyc > 0 && n == hold_cyc) begin
                chk("no_start_while_held", 64'(n_st[i] - s0), 64'd0);
                hold[i] = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            trig[i] = 1'b0;
            if (retrig && !fired && n_st[i] == s0 + 1) begin
                trig[i] = 1'b1;
                res[i] = 16'h1234;
                fired = 1'b1;
            end
        end
        trig[i] = 1'b0;
        check_txn(i, t, v, s0, d0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, n;
        reset = 1'b0;
        trig[0] = 1'b0;
        trig[1] = 1'b0;
        res[0] = 16'h0000;
        res[1] = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("reset_tx_start", 64'(tx_start[i]), 64'd0);
            chk("reset_tx_data", 64'(tx_data[i]), 64'd0);
            chk("reset_busy", 64'(busy[i]), 64'd0);
            chk("reset_done", 64'(done[i]), 64'd0);
        end
        reset = 1'b1;
        idle(3);

        for (int i = 0; i < 2; i++) begin
            run(i, 16'hA55A, 1'b0, 0);
            idle(5);
            hold[i] = 1'b1;
            idle(2);
            run(i, 16'($urandom), 1'b0, 20);
            idle(5);
            run(i, 16'hA55A, 1'b1, 0);
            s0 = n_st[i];
            idle(30);
            chk("no_extra_frame", 64'(n_st[i] - s0), 64'd0);
            run(i, 16'($urandom), 1'b0, 0);
            run(i, 16'($urandom), 1'b0, 0);
            for (int r = 0; r < 4; r++) begin
                idle(int'($urandom_range(1, 6)));
                run(i, 16'($urandom), 1'b0, 0);
            end
        end

        s0 = n_st[0];
        d0 = n_dn[0];
        trig[0] = 1'b1;
        res[0] = 16'hBEEF;
        @(posedge clk); #1;
        trig[0] = 1'b0;
        n = 0;
        while (n_st[0] == s0 && n < 500) begin
            @(posedge clk); #3; n++;
        end
        while (txb[0] !== 1'b1 && n < 500) begin
            @(posedge clk); #3; n++;
        end
        while (txb[0] !== 1'b0 && n < 500) begin
            @(posedge clk); #3; n++;
        end
        chk("reset_setup_wait_expired", 64'(n >= 500), 64'd0);
        @(posedge clk); #3;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        chk("midrst_tx_start", 64'(tx_start[0]), 64'd0);
        chk("midrst_tx_data", 64'(tx_data[0]), 64'd0);
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_done", 64'(done[0]), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        s0 = n_st[0];
        idle(30);
        chk("no_start_after_reset", 64'(n_st[0] - s0), 64'd0);
        chk("no_done_after_reset", 64'(n_dn[0] - d0), 64'd0);
        run(0, 16'h00FF, 1'b0, 0);
        run(1, 16'h00FF, 1'b0, 0);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
